irq_ctrl: RTL and testbench

- Interrupt controller directly upstream of the RISC_V core's 4-bit `interrupt` input.
- Collects up to NSRC raw sources: timer overflow, external pin, software, spare.
- Per source: optional synchronisation, edge or level qualification, pending and enable state.
- Presents one prioritised one-hot request to the core; holds it until the core acknowledges trap entry; blocks further requests until the core executes `mret`.

---
 rtl/irq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller feeding the core's one-hot interrupt input.
//
// Collects NSRC sources (bit0 timer ovf, bit1 ext_inter, bit2 software,
// bit3 spare), qualifies each as rising-edge latched or level-sensitive,
// masks with ENABLE and presents the lowest-index pending request as a
// registered one-hot vector. The request is held until irq_ack, after which
// no new request is presented until mret.
//
// Optional feature: define IRQ_SYNC_EN to add a SYNC_STAGES-deep
// synchroniser on every source bit (needed for asynchronous pins).
//
// Ports:
//   clk         core clock
//   rst         synchronous active-high reset
//   src         raw interrupt sources
//   irq_ack     trap taken for the presented request (1-cycle pulse)
//   mret        trap handler returned (1-cycle pulse)
//   cfg_we      configuration write strobe
//   cfg_addr    0 ENABLE, 1 PENDING (W1C on edge bits), 2 STATUS, 3 reserved
//   cfg_wdata   configuration write data
//   cfg_rdata   combinational read data for cfg_addr
//   irq_o       registered one-hot request, zero when nothing is presented
//   irq_active  high while a trap is being serviced
module irq_ctrl #(
    parameter int              NSRC        = 4,
    parameter logic [NSRC-1:0] EDGE_MASK   = 4'b0011,
    parameter int              SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    input  logic            irq_ack,
    input  logic            mret,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [NSRC-1:0] cfg_wdata,
    output logic [NSRC-1:0] cfg_rdata,
    output logic [NSRC-1:0] irq_o,
    output logic            irq_active
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SERVICE = 2'd2
    } state_t;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("irq_ctrl: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [NSRC-1:0] s, s_d;
    logic [NSRC-1:0] pend_q, pend_d, pending;
    logic [NSRC-1:0] enable_q;
    logic [NSRC-1:0] req, lowest;
    logic [NSRC-1:0] win_q, win_d;
    logic [NSRC-1:0] irq_q, irq_d;
    logic [NSRC-1:0] rise, clr;
    logic [1:0]      win_idx;
    logic [NSRC+3:0] status_ext;

    // ---------------- source conditioning ----------------
`ifdef IRQ_SYNC_EN
    logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], src};
    end

    assign s = sync_q[SYNC_STAGES-1];
`else
    assign s = src;
`endif

    always_ff @(posedge clk) begin
        if (rst) s_d <= '0;
        else     s_d <= s;
    end

    // Edge bits latch; level bits mirror s and pend_q stays zero there.
    assign rise    = s & ~s_d & EDGE_MASK;
    assign pending = (pend_q & EDGE_MASK) | (s & ~EDGE_MASK);
    assign req     = pending & enable_q;
    // Isolate lowest set bit: lowest index has highest priority.
    assign lowest  = req & (~req + {{(NSRC-1){1'b0}}, 1'b1});

    always_comb begin
        clr = '0;
        if (cfg_we && cfg_addr == 2'd1) clr = clr | cfg_wdata;
        if (state_q == PRESENT && irq_ack) clr = clr | win_q;
        // A new edge in the same cycle as a clear keeps the bit set.
        pend_d = ((pend_q & ~clr) | rise) & EDGE_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            enable_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (cfg_we && cfg_addr == 2'd0) enable_q <= cfg_wdata;
        end
    end

    // ---------------- request FSM ----------------
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        irq_d   = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    win_d   = lowest;
                    irq_d   = lowest;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // Ack beats a simultaneous withdrawal.
                if (irq_ack)                state_d = SERVICE;
                else if ((req & win_q) == '0) state_d = IDLE;
                else                        irq_d   = win_q;
            end
            SERVICE: begin
                if (mret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            irq_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            irq_q   <= irq_d;
        end
    end

    assign irq_o      = irq_q;
    assign irq_active = (state_q == SERVICE);

    // ---------------- configuration read ----------------
    always_comb begin
        win_idx = 2'd0;
        for (int i = 0; i < NSRC; i++)
            if (win_q[i]) win_idx = 2'(i);
    end

    assign status_ext = {{NSRC{1'b0}}, state_q, win_idx};

    always_comb begin
        cfg_rdata = '0;
        if (!rst) begin
            case (cfg_addr)
                2'd0:    cfg_rdata = enable_q;
                2'd1:    cfg_rdata = pending;
                2'd2:    cfg_rdata = status_ext[NSRC-1:0];
                default: cfg_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: reset, single edge, priority, withdrawal,
// collisions, level source, config corner cases and reset while servicing.
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 4;   // src rise to irq_o, edge source, 2-stage sync
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] src = '0;
    logic       irq_ack = 1'b0;
    logic       mret = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [3:0] cfg_wdata = '0;
    logic [3:0] cfg_rdata;
    logic [3:0] irq_o;
    logic       irq_active;

    int n_chk = 0;
    int n_fail = 0;
    logic [3:0] v;

    irq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .src        (src),
        .irq_ack    (irq_ack),
        .mret       (mret),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .irq_o      (irq_o),
        .irq_active (irq_active)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [3:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [3:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // one-cycle source pulse, then wait until an edge request is presented
    task automatic pulse_and_wait(input logic [3:0] bits);
        src = bits;
        tick();
        src = '0;
        tick(LAT - 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_chk++; if (irq_o !== 4'b0000) begin n_fail++; $display("FAIL reset_irq irq_o=%b exp=0000", irq_o); end
        n_chk++; if (irq_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got=%b exp=0", irq_active); end
        rd(2'd2, v);
        n_chk++; if (v !== 4'b0000) begin n_fail++; $display("FAIL reset_status got=%b exp=0000", v); end
        rst = 1'b0;
        rd(2'd0, v);
        n_chk++; if (v !== 4'b0000) begin n_fail++; $display("FAIL reset_enable got=%b exp=0000", v); end
    endtask

    task automatic test_single_edge();
        cfg_write(2'd0, 4'b0011);
        src = 4'b0010;
        tick(LAT - 1);
        src = '0;
        n_chk++; if (irq_o !== 4'b0000) begin n_fail++; $display("FAIL single_early irq_o=%b exp=0000", irq_o); end
        tick();
        n_chk++; if (irq_o !== 4'b0010) begin n_fail++; $display("FAIL single_present irq_o=%b exp=0010", irq_o); end
        rd(2'd2, v);
        n_chk++; if (v !== 4'b0101) begin n_fail++; $display("FAIL single_status got=%b exp=0101", v); end
        tick(2);
        n_chk++; if (irq_o !== 4'b0010) begin n_fail++; $display("FAIL single_hold irq_o=%b exp=0010", irq_o); end
        mret = 1'b1; tick(); mret = 1'b0;   // mret ignored in PRESENT
        n_chk++; if (irq_o !== 4'b0010) begin n_fail++; $display("FAIL mret_in_present irq_o=%b exp=0010", irq_o); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        n_chk++; if (irq_o !== 4'b0000 || irq_active !== 1'b1) begin n_fail++; $display("FAIL single_ack irq_o=%b active=%b exp=0000/1", irq_o, irq_active); end
        rd(2'd1, v);
        n_chk++; if (v !== 4'b0000) begin n_fail++; $display("FAIL single_pend_clr got=%b exp=0000", v); end
        rd(2'd2, v);
        n_chk++; if (v !== 4'b1001) begin n_fail++; $display("FAIL service_status got=%b exp=1001", v); end
        mret = 1'b1; tick(); mret = 1'b0;
        n_chk++; if (irq_active !== 1'b0 || irq_o !== 4'b0000) begin n_fail++; $display("FAIL single_mret active=%b irq_o=%b exp=0/0000", irq_active, irq_o); end
    endtask

    task automatic test_priority();
        pulse_and_wait(4'b0011);
        n_chk++; if (irq_o !== 4'b0001) begin n_fail++; $display("FAIL prio_first irq_o=%b exp=0001", irq_o); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        rd(2'd1, v);
        n_chk++; if (v !== 4'b0010) begin n_fail++; $display("FAIL prio_pend got=%b exp=0010", v); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;   // ack ignored in SERVICE
        n_chk++; if (irq_active !== 1'b1) begin n_fail++; $display("FAIL ack_in_service active=%b exp=1", irq_active); end
        mret = 1'b1; tick(); mret = 1'b0;
        n_chk++; if (irq_o !== 4'b0000) begin n_fail++; $display("FAIL prio_idle irq_o=%b exp=0000", irq_o); end
        tick();
        n_chk++; if (irq_o !== 4'b0010) begin n_fail++; $display("FAIL prio_second irq_o=%b exp=0010", irq_o); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        mret = 1'b1; tick(); mret = 1'b0;
    endtask

    task automatic test_withdraw();
        pulse_and_wait(4'b0001);
        n_chk++; if (irq_o !== 4'b0001) begin n_fail++; $display("FAIL wd_present irq_o=%b exp=0001", irq_o); end
        cfg_write(2'd0, 4'b0010);
        tick();
        n_chk++; if (irq_o !== 4'b0000) begin n_fail++; $display("FAIL wd_withdrawn irq_o=%b exp=0000", irq_o); end
        rd(2'd2, v);
        n_chk++; if (v[3:2] !== 2'b00) begin n_fail++; $display("FAIL wd_state got=%b exp=00", v[3:2]); end
        rd(2'd1, v);
        n_chk++; if (v !== 4'b0001) begin n_fail++; $display("FAIL wd_pend got=%b exp=0001", v); end
        cfg_write(2'd0, 4'b0011);
        tick();
        n_chk++; if (irq_o !== 4'b0001) begin n_fail++; $display("FAIL wd_represent irq_o=%b exp=0001", irq_o); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        mret = 1'b1; tick(); mret = 1'b0;
    endtask

    task automatic test_collisions();
        cfg_write(2'd0, 4'b0000);
        pulse_and_wait(4'b0010);
        rd(2'd1, v);
        n_chk++; if (v !== 4'b0010) begin n_fail++; $display("FAIL col_pre_pend got=%b exp=0010", v); end
        src = 4'b0010;
        tick(LAT - 2);
        cfg_write(2'd1, 4'b0010);   // W1C lands on the same edge as the new rise
        src = '0;
        rd(2'd1, v);
        n_chk++; if (v !== 4'b0010) begin n_fail++; $display("FAIL col_set_wins got=%b exp=0010", v); end
        cfg_write(2'd1, 4'b0010);
        rd(2'd1, v);
        n_chk++; if (v !== 4'b0000) begin n_fail++; $display("FAIL w1c_clear got=%b exp=0000", v); end
        cfg_write(2'd0, 4'b0011);
        pulse_and_wait(4'b0001);
        n_chk++; if (irq_o !== 4'b0001) begin n_fail++; $display("FAIL col_present irq_o=%b exp=0001", irq_o); end
        irq_ack = 1'b1;
        cfg_write(2'd0, 4'b0000);
        irq_ack = 1'b0;
        n_chk++; if (irq_active !== 1'b1 || irq_o !== 4'b0000) begin n_fail++; $display("FAIL col_ack_wins active=%b irq_o=%b exp=1/0000", irq_active, irq_o); end
        mret = 1'b1; tick(); mret = 1'b0;
    endtask

    task automatic test_level();
        cfg_write(2'd0, 4'b0100);
        src = 4'b0100;
        tick(LAT - 1);
        n_chk++; if (irq_o !== 4'b0100) begin n_fail++; $display("FAIL lvl_present irq_o=%b exp=0100", irq_o); end
        cfg_write(2'd1, 4'b0100);   // W1C has no effect on a level bit
        n_chk++; if (irq_o !== 4'b0100) begin n_fail++; $display("FAIL lvl_w1c irq_o=%b exp=0100", irq_o); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        rd(2'd1, v);
        n_chk++; if (v !== 4'b0100) begin n_fail++; $display("FAIL lvl_pend got=%b exp=0100", v); end
        mret = 1'b1; tick(); mret = 1'b0;
        tick();
        n_chk++; if (irq_o !== 4'b0100) begin n_fail++; $display("FAIL lvl_represent irq_o=%b exp=0100", irq_o); end
        src = '0;
        tick(LAT - 1);
        n_chk++; if (irq_o !== 4'b0000 || irq_active !== 1'b0) begin n_fail++; $display("FAIL lvl_withdraw irq_o=%b active=%b exp=0000/0", irq_o, irq_active); end
    endtask

    task automatic test_reserved();
        cfg_write(2'd0, 4'b0001);
        cfg_write(2'd3, 4'b1111);
        rd(2'd3, v);
        n_chk++; if (v !== 4'b0000) begin n_fail++; $display("FAIL rsv_read got=%b exp=0000", v); end
        rd(2'd0, v);
        n_chk++; if (v !== 4'b0001) begin n_fail++; $display("FAIL rsv_write got=%b exp=0001", v); end
    endtask

    task automatic test_reset_service();
        pulse_and_wait(4'b0001);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        src = 4'b0001;   // latch a new pending edge during SERVICE
        tick(LAT);
        src = '0;
        n_chk++; if (irq_active !== 1'b1) begin n_fail++; $display("FAIL rs_service active=%b exp=1", irq_active); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_chk++; if (irq_o !== 4'b0000 || irq_active !== 1'b0) begin n_fail++; $display("FAIL rs_out irq_o=%b active=%b exp=0000/0", irq_o, irq_active); end
        rd(2'd0, v);
        n_chk++; if (v !== 4'b0000) begin n_fail++; $display("FAIL rs_enable got=%b exp=0000", v); end
        rd(2'd1, v);
        n_chk++; if (v !== 4'b0000) begin n_fail++; $display("FAIL rs_pend got=%b exp=0000", v); end
    endtask

    initial begin
        tick();
        test_reset();
        test_single_edge();
        test_priority();
        test_withdraw();
        test_collisions();
        test_level();
        test_reserved();
        test_reset_service();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
